// File: rtl/xilinx_fifo_sync_ctrl_if.sv
// Valid/ready handshake bundle between the FIFO controller and its upstream/downstream users.
// master = user side (drives write data, consumes read data); slave = controller side.
interface xilinx_fifo_sync_ctrl_if #(
    parameter int DATA_WIDTH = 36
);
    logic                  S_VALID;
    logic                  S_READY;
    logic [DATA_WIDTH-1:0] S_DATA;
    logic                  M_VALID;
    logic                  M_READY;
    logic [DATA_WIDTH-1:0] M_DATA;

    modport master (
        output S_VALID, S_DATA, M_READY,
        input  S_READY, M_VALID, M_DATA
    );

    modport slave (
        input  S_VALID, S_DATA, M_READY,
        output S_READY, M_VALID, M_DATA
    );
endinterface

// File: rtl/xilinx_fifo_sync_ctrl.sv
// Reset sequencer and valid/ready adapter for a FIFO18E1/FIFO36E1 synchronous FIFO wrapper.
// Optional per-error saturating counters: define XILINX_FIFO_SYNC_CTRL_ERR_CNT_EN.
//
// state       | meaning
// ------------+------------------------------------------------------------
// ST_RST_HOLD | FIFO_RST driven high for RST_HOLD_CYCLES
// ST_WAIT     | FIFO_RST low, WREN/RDEN held low for RST_WAIT_CYCLES
// ST_RUN      | INIT_DONE high, handshakes active
module xilinx_fifo_sync_ctrl #(
    parameter int DATA_WIDTH      = 36,
    parameter int DO_REG          = 0,
    parameter int RST_HOLD_CYCLES = 5,
    parameter int RST_WAIT_CYCLES = 5
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic                   FLUSH,
    xilinx_fifo_sync_ctrl_if.slave bus,
    output logic                   INIT_DONE,
    output logic                   ERR_STICKY,
    output logic [31:0]            ERR_COUNT,
    output logic                   FIFO_RST,
    output logic                   FIFO_WREN,
    output logic                   FIFO_RDEN,
    output logic [DATA_WIDTH-1:0]  FIFO_DI,
    input  logic [DATA_WIDTH-1:0]  FIFO_DO,
    input  logic                   FIFO_FULL,
    input  logic                   FIFO_EMPTY,
    input  logic                   FIFO_WRERR,
    input  logic                   FIFO_RDERR
);

    localparam int RL      = 1 + DO_REG;
    localparam int CNT_MAX = (RST_HOLD_CYCLES > RST_WAIT_CYCLES) ? RST_HOLD_CYCLES : RST_WAIT_CYCLES;
    localparam int CW      = $clog2(CNT_MAX);

    typedef enum logic [1:0] {
        ST_RST_HOLD = 2'd0,
        ST_WAIT     = 2'd1,
        ST_RUN      = 2'd2
    } state_t;

    state_t          state_q;
    logic [CW-1:0]   cnt_q;
    logic            fifo_rst_q;
    logic            init_done_q;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q     <= ST_RST_HOLD;
            cnt_q       <= '0;
            fifo_rst_q  <= 1'b1;
            init_done_q <= 1'b0;
        end else if (FLUSH) begin
            state_q     <= ST_RST_HOLD;
            cnt_q       <= '0;
            fifo_rst_q  <= 1'b1;
            init_done_q <= 1'b0;
        end else begin
            case (state_q)
                ST_RST_HOLD: begin
                    if (cnt_q == CW'(RST_HOLD_CYCLES - 1)) begin
                        state_q    <= ST_WAIT;
                        cnt_q      <= '0;
                        fifo_rst_q <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                ST_WAIT: begin
                    if (cnt_q == CW'(RST_WAIT_CYCLES - 1)) begin
                        state_q     <= ST_RUN;
                        cnt_q       <= '0;
                        init_done_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                ST_RUN: begin
                    state_q <= ST_RUN;
                end
                default: begin
                    state_q     <= ST_RST_HOLD;
                    cnt_q       <= '0;
                    fifo_rst_q  <= 1'b1;
                    init_done_q <= 1'b0;
                end
            endcase
        end
    end

    assign FIFO_RST  = fifo_rst_q;
    assign INIT_DONE = init_done_q;

    // Write side: ready follows FULL directly so a write is never presented while full.
    assign bus.S_READY = init_done_q && !FIFO_FULL;
    assign FIFO_WREN   = bus.S_VALID && bus.S_READY;
    assign FIFO_DI     = bus.S_DATA;

    logic [DATA_WIDTH-1:0] skid_q [4];
    logic [1:0]            rd_ptr_q;
    logic [1:0]            wr_ptr_q;
    logic [2:0]            occ_q;
    logic [2:0]            occ_d;
    logic [RL-1:0]         infl_q;
    logic [RL-1:0]         infl_d;
    logic [2:0]            inflight;
    logic                  rden;
    logic                  cap;
    logic                  pop;

    always_comb begin
        inflight = '0;
        for (int i = 0; i < RL; i++) begin
            inflight = inflight + 3'(infl_q[i]);
        end
    end

    // Credit: words already buffered plus reads still in the RAM pipeline never exceed 4.
    assign rden      = init_done_q && !FIFO_EMPTY && ((occ_q + inflight) < 3'd4);
    assign FIFO_RDEN = rden;
    assign cap       = infl_q[RL-1];
    assign pop       = (occ_q != 3'd0) && bus.M_READY;

    assign infl_d = (infl_q << 1) | RL'(rden);
    assign occ_d  = occ_q + 3'(cap) - 3'(pop);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            infl_q   <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            occ_q    <= '0;
            for (int i = 0; i < 4; i++) begin
                skid_q[i] <= '0;
            end
        end else if (FLUSH) begin
            infl_q   <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            occ_q    <= '0;
        end else begin
            infl_q <= infl_d;
            occ_q  <= occ_d;
            if (cap) begin
                skid_q[wr_ptr_q] <= FIFO_DO;
                wr_ptr_q         <= wr_ptr_q + 2'd1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 2'd1;
            end
        end
    end

    assign bus.M_VALID = (occ_q != 3'd0);
    assign bus.M_DATA  = skid_q[rd_ptr_q];

    logic err_sticky_q;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            err_sticky_q <= 1'b0;
        end else if (FLUSH) begin
            err_sticky_q <= 1'b0;
        end else if (FIFO_WRERR || FIFO_RDERR) begin
            err_sticky_q <= 1'b1;
        end
    end

    assign ERR_STICKY = err_sticky_q;

`ifdef XILINX_FIFO_SYNC_CTRL_ERR_CNT_EN
    logic [15:0] wrerr_cnt_q;
    logic [15:0] rderr_cnt_q;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            wrerr_cnt_q <= '0;
            rderr_cnt_q <= '0;
        end else if (FLUSH) begin
            wrerr_cnt_q <= '0;
            rderr_cnt_q <= '0;
        end else begin
            if (FIFO_WRERR && (wrerr_cnt_q != 16'hFFFF)) begin
                wrerr_cnt_q <= wrerr_cnt_q + 16'd1;
            end
            if (FIFO_RDERR && (rderr_cnt_q != 16'hFFFF)) begin
                rderr_cnt_q <= rderr_cnt_q + 16'd1;
            end
        end
    end

    assign ERR_COUNT = {wrerr_cnt_q, rderr_cnt_q};
`else
    assign ERR_COUNT = 32'd0;
`endif

    skid_no_overflow: assert property (@(posedge CLK) disable iff (RST)
        !(cap && !pop && (occ_q == 3'd4)));

    no_write_when_full: assert property (@(posedge CLK) disable iff (RST)
        !(FIFO_WREN && FIFO_FULL));

    no_read_when_empty: assert property (@(posedge CLK) disable iff (RST)
        !(FIFO_RDEN && FIFO_EMPTY));

endmodule

// File: tb/tb_xilinx_fifo_sync_ctrl.sv
// Directed bench for xilinx_fifo_sync_ctrl with a 16-deep behavioural FIFO wrapper (DO_REG=1).
module tb_xilinx_fifo_sync_ctrl;
    localparam int DW     = 36;
    localparam int DO_REG = 1;
    localparam int DEPTH  = 16;

    logic clk_sys = 1'b0;
    logic rst     = 1'b1;
    logic flush   = 1'b0;
    always #5 clk_sys = ~clk_sys;

    xilinx_fifo_sync_ctrl_if #(.DATA_WIDTH(DW)) bus ();

    logic          init_done, err_sticky;
    logic [31:0]   err_count;
    logic          fifo_rst, fifo_wren, fifo_rden;
    logic [DW-1:0] fifo_di, fifo_do;
    logic          fifo_full, fifo_empty, fifo_wrerr, fifo_rderr;

    xilinx_fifo_sync_ctrl #(
        .DATA_WIDTH(DW), .DO_REG(DO_REG), .RST_HOLD_CYCLES(5), .RST_WAIT_CYCLES(5)
    ) dut (
        .CLK(clk_sys), .RST(rst), .FLUSH(flush), .bus(bus),
        .INIT_DONE(init_done), .ERR_STICKY(err_sticky), .ERR_COUNT(err_count),
        .FIFO_RST(fifo_rst), .FIFO_WREN(fifo_wren), .FIFO_RDEN(fifo_rden),
        .FIFO_DI(fifo_di), .FIFO_DO(fifo_do),
        .FIFO_FULL(fifo_full), .FIFO_EMPTY(fifo_empty),
        .FIFO_WRERR(fifo_wrerr), .FIFO_RDERR(fifo_rderr)
    );

    // Behavioural FIFO wrapper: registered count, read data after RL = 1 + DO_REG edges.
    logic [DW-1:0] mem [DEPTH];
    logic [3:0]    wp = '0, rp = '0;
    logic [4:0]    cnt = '0;
    logic [DW-1:0] do1 = '0, do2 = '0;
    logic          force_wrerr = 1'b0, force_rderr = 1'b0;
    logic          wr_ok, rd_ok;

    assign fifo_full  = (cnt == 5'(DEPTH));
    assign fifo_empty = (cnt == 5'd0);
    assign fifo_do    = (DO_REG != 0) ? do2 : do1;
    assign wr_ok      = fifo_wren && !fifo_full;
    assign rd_ok      = fifo_rden && !fifo_empty;
    assign fifo_wrerr = force_wrerr | (fifo_wren & fifo_full);
    assign fifo_rderr = force_rderr | (fifo_rden & fifo_empty);

    always @(posedge clk_sys) begin
        if (fifo_rst) begin
            wp <= '0; rp <= '0; cnt <= '0; do1 <= '0; do2 <= '0;
        end else begin
            if (wr_ok) begin
                mem[wp] <= fifo_di;
                wp      <= wp + 4'd1;
            end
            if (rd_ok) begin
                do1 <= mem[rp];
                rp  <= rp + 4'd1;
            end
            cnt <= cnt + 5'(wr_ok) - 5'(rd_ok);
            do2 <= do1;
        end
    end

    int            cyc = 0;
    logic [DW-1:0] rx_q [$];
    int            rx_cyc [$];
    int            rden_cnt = 0, wr_cnt = 0, wren_full_cnt = 0;

    always @(posedge clk_sys) cyc <= cyc + 1;

    always @(negedge clk_sys) begin
        if (bus.M_VALID && bus.M_READY) begin
            rx_q.push_back(bus.M_DATA);
            rx_cyc.push_back(cyc);
        end
        if (fifo_rden) rden_cnt++;
        if (fifo_wren) wr_cnt++;
        if (fifo_wren && fifo_full) wren_full_cnt++;
    end

    int n_chk = 0;
    int n_err = 0;

    task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic wait_rx(input string tag, input int n, input int bound);
        for (int i = 0; i < bound && rx_q.size() < n; i++) step();
        check_val({tag, "_rx_count"}, rx_q.size(), n);
    endtask

    // Called right after an edge in cycle 0 of a reset sequence; ends in cycle 10.
    task automatic check_reset_seq(input string tag);
        bus.S_VALID = 1'b1;
        bus.S_DATA  = 36'hDEAD;
        for (int k = 0; k <= 10; k++) begin
            @(negedge clk_sys);
            check_val($sformatf("%s_fifo_rst_k%0d", tag, k), fifo_rst, (k < 5));
            check_val($sformatf("%s_init_done_k%0d", tag, k), init_done, (k == 10));
            check_val($sformatf("%s_s_ready_k%0d", tag, k), bus.S_READY, (k == 10));
            check_val($sformatf("%s_en_k%0d", tag, k), {fifo_wren, fifo_rden}, 2'b00);
            check_val($sformatf("%s_m_valid_k%0d", tag, k), bus.M_VALID, 1'b0);
            if (k < 10) begin
                step();
                if (k == 9) bus.S_VALID = 1'b0;
            end
        end
    endtask

    logic [31:0] exp_cnt;
    int w, base, wbase, wfull;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bus.S_VALID = 1'b0;
        bus.S_DATA  = '0;
        bus.M_READY = 1'b0;

        // Held in reset.
        step();
        @(negedge clk_sys);
        check_val("rst_fifo_rst", fifo_rst, 1'b1);
        check_val("rst_outputs", {bus.S_READY, bus.M_VALID, init_done, fifo_wren, fifo_rden, err_sticky}, 6'b0);
        check_val("rst_err_count", err_count, 32'd0);
        check_val("rst_m_data", bus.M_DATA, 36'd0);
        step();
        rst = 1'b0;
        check_reset_seq("init");

        // Eight back-to-back words with M_READY high.
        step();
        bus.M_READY = 1'b1;
        rx_q.delete(); rx_cyc.delete();
        for (int i = 1; i <= 8; i++) begin
            if (i == 1) w = cyc;
            bus.S_VALID = 1'b1;
            bus.S_DATA  = 36'(i);
            step();
        end
        bus.S_VALID = 1'b0;
        wait_rx("stream", 8, 50);
        for (int i = 0; i < 8 && i < rx_q.size(); i++) begin
            check_val($sformatf("stream_data%0d", i), rx_q[i], 36'(i + 1));
            check_val($sformatf("stream_cyc%0d", i), rx_cyc[i], w + 4 + i);
        end
        check_val("stream_err_sticky", err_sticky, 1'b0);

        // Backpressure: ten words written, only four may leave the FIFO.
        bus.M_READY = 1'b0;
        rx_q.delete(); rx_cyc.delete();
        base = rden_cnt;
        for (int i = 0; i < 10; i++) begin
            bus.S_VALID = 1'b1;
            bus.S_DATA  = 36'(8'h11 + i);
            step();
        end
        bus.S_VALID = 1'b0;
        for (int i = 0; i < 20; i++) step();
        check_val("bp_rden_pulses", rden_cnt - base, 4);
        check_val("bp_m_valid", bus.M_VALID, 1'b1);
        check_val("bp_m_data", bus.M_DATA, 36'h11);
        check_val("bp_no_pop", rx_q.size(), 0);
        bus.M_READY = 1'b1;
        wait_rx("bp", 10, 60);
        for (int i = 0; i < 10 && i < rx_q.size(); i++)
            check_val($sformatf("bp_data%0d", i), rx_q[i], 36'(8'h11 + i));
        check_val("bp_rden_total", rden_cnt - base, 10);

        // Fill until FULL: 16 in the FIFO plus 4 in the skid buffer.
        bus.M_READY = 1'b0;
        rx_q.delete(); rx_cyc.delete();
        wbase = wr_cnt;
        wfull = wren_full_cnt;
        for (int i = 0; i < 40; i++) begin
            bus.S_VALID = 1'b1;
            bus.S_DATA  = 36'(12'h100 + (wr_cnt - wbase));
            step();
        end
        bus.S_VALID = 1'b1;
        @(negedge clk_sys);
        check_val("full_s_ready", bus.S_READY, 1'b0);
        check_val("full_flag", fifo_full, 1'b1);
        check_val("full_accepted", wr_cnt - wbase, 20);
        check_val("full_no_wren", wren_full_cnt - wfull, 0);
        step();
        bus.S_VALID = 1'b0;
        bus.M_READY = 1'b1;
        step();
        bus.M_READY = 1'b0;
        @(negedge clk_sys);
        check_val("full_pop_s_ready_p1", bus.S_READY, 1'b0);
        step();
        @(negedge clk_sys);
        check_val("full_pop_s_ready_p2", bus.S_READY, 1'b1);
        step();
        bus.M_READY = 1'b1;
        wait_rx("full", 20, 80);
        for (int i = 0; i < 20 && i < rx_q.size(); i++)
            check_val($sformatf("full_data%0d", i), rx_q[i], 36'(12'h100 + i));

        // Flush with three words buffered and one read still in flight.
        bus.M_READY = 1'b0;
        rx_q.delete(); rx_cyc.delete();
        base = rden_cnt;
        for (int i = 0; i < 4; i++) begin
            bus.S_VALID = 1'b1;
            bus.S_DATA  = 36'(12'h200 + i);
            step();
        end
        bus.S_VALID = 1'b0;
        begin
            int n = 0;
            while (n < 30 && (rden_cnt - base) < 4) begin
                step();
                n++;
            end
            check_val("flush_rden_seen", rden_cnt - base, 4);
        end
        step();
        flush = 1'b1;
        @(negedge clk_sys);
        check_val("preflush_m_valid", bus.M_VALID, 1'b1);
        check_val("preflush_m_data", bus.M_DATA, 36'h200);
        step();
        flush = 1'b0;
        check_reset_seq("flush");
        bus.M_READY = 1'b1;
        for (int i = 0; i < 10; i++) step();
        check_val("flush_nothing_rx", rx_q.size(), 0);
        check_val("flush_m_valid_after", bus.M_VALID, 1'b0);

        // Error reporting.
        check_val("pre_err_sticky", err_sticky, 1'b0);
        force_wrerr = 1'b1;
        step(); step(); step();
        force_wrerr = 1'b0;
        force_rderr = 1'b1;
        step(); step();
        force_rderr = 1'b0;
        @(negedge clk_sys);
`ifdef XILINX_FIFO_SYNC_CTRL_ERR_CNT_EN
        exp_cnt = {16'd3, 16'd2};
`else
        exp_cnt = 32'd0;
`endif
        check_val("err_sticky_set", err_sticky, 1'b1);
        check_val("err_count", err_count, exp_cnt);
        step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        check_reset_seq("errflush");
        check_val("err_sticky_cleared", err_sticky, 1'b0);
        check_val("err_count_cleared", err_count, 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
